// File: rtl/sccb_pkg.sv
// Shared SCCB slave definitions: protocol FSM states, default device address, byte bit counting.
package sccb_pkg;
    localparam logic [6:0] DEV_ADDR_DEF  = 7'h3C;
    localparam int         BITS_PER_BYTE = 8;
    localparam logic [2:0] LAST_BIT      = 3'(BITS_PER_BYTE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_ACK_DEV, S_AHI, S_ACK_AHI, S_ALO, S_ACK_ALO,
        S_WDATA, S_ACK_W, S_RDATA, S_RACK
    } state_t;
endpackage

// File: rtl/sccb_slave_regfile.sv
// Single-port 2^REG_AW x 8 register file; synchronous write, registered read (1 clk latency),
// no backpressure -- the SCCB ACK bit leaves ample time for the read data to settle.
module sccb_slave_regfile #(
    parameter int REG_AW = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [REG_AW-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [2**REG_AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/sccb_slave.sv
// SCCB slave with 16-bit register addressing; write pulse 1 clk after the 8th data SCL rise, no backpressure.
// Define SCCB_SLAVE_RD_EN to add sequential reads; without it any R/W=1 address phase is NACKed.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
    parameter int         REG_AW      = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        reg_wr_en,
    output logic [15:0] reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  sh_q, sh_d;
    logic [15:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d, byte_in, rd_dat;
    logic        oe_q, oe_d, busy_q, busy_d, wr_en_q, wr_en_d, last, rd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= SYNC_STAGES'({scl_sync_q, scl});
            sda_sync_q <= SYNC_STAGES'({sda_sync_q, sda_i});
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // SCL history is ignored so a START landing on a sampling rise still wins over the bit.
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;
    assign byte_in   = {sh_q, sda_s};
    assign last      = (cnt_q == LAST_BIT);
`ifdef SCCB_SLAVE_RD_EN
    assign rd_ok     = 1'b1;
`else
    assign rd_ok     = ~byte_in[0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = S_DEV;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_DEV, S_AHI, S_ALO, S_WDATA: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        case (state_q)
                            S_DEV: begin
                                if (byte_in[7:1] == DEV_ADDR && rd_ok) begin
                                    state_d = S_ACK_DEV;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                            S_AHI: begin
                                ptr_d[15:8] = byte_in;
                                state_d     = S_ACK_AHI;
                            end
                            S_ALO: begin
                                ptr_d[7:0] = byte_in;
                                state_d    = S_ACK_ALO;
                            end
                            default: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                                ptr_d     = ptr_q + 16'd1;
                                state_d   = S_ACK_W;
                            end
                        endcase
                    end
                end
                // First fall pulls SDA low for the ACK slot, the second fall ends it.
                S_ACK_DEV, S_ACK_AHI, S_ACK_ALO, S_ACK_W: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d  = 1'b0;
                        cnt_d = '0;
                        case (state_q)
                            S_ACK_DEV: begin
                                state_d = S_AHI;
`ifdef SCCB_SLAVE_RD_EN
                                if (sh_q[0]) begin
                                    state_d = S_RDATA;
                                    sh_d    = rd_dat[6:0];
                                    oe_d    = ~rd_dat[7];
                                end
`endif
                            end
                            S_ACK_AHI: state_d = S_ALO;
                            default:   state_d = S_WDATA;
                        endcase
                    end
                end
`ifdef SCCB_SLAVE_RD_EN
                S_RDATA: if (scl_fall) begin
                    if (last) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        ptr_d   = ptr_q + 16'd1;
                        state_d = S_RACK;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        oe_d  = ~sh_q[6];
                        sh_d  = {sh_q[5:0], 1'b0};
                    end
                end
                // cnt_q=1 marks that the master ACKed and another byte is wanted.
                S_RACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = S_IDLE;
                        else       cnt_d   = 3'd1;
                    end else if (scl_fall && cnt_q == 3'd1) begin
                        state_d = S_RDATA;
                        cnt_d   = '0;
                        sh_d    = rd_dat[6:0];
                        oe_d    = ~rd_dat[7];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    sccb_slave_regfile #(.REG_AW(REG_AW)) u_regfile (
        .clk     (clk),
        .we_i    (wr_en_q),
        .addr_i  (wr_en_q ? wr_addr_q[REG_AW-1:0] : ptr_q[REG_AW-1:0]),
        .wdata_i (wr_data_q),
        .rdata_o (rd_dat)
    );

`ifndef SCCB_SLAVE_RD_EN
    logic [7:0] unused_rd_dat;
    assign unused_rd_dat = rd_dat;
`endif

    assign sda_oe      = oe_q;
    assign busy        = busy_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: open-drain SCCB master tasks, queue scoreboard on register writes.
module tb_sccb_slave;
    localparam logic [6:0] DEV = 7'h3C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_oe, reg_wr_en, busy;
    logic [15:0] reg_wr_addr;
    logic [7:0]  reg_wr_data;
    wire         sda_line;
    assign sda_line = sda_m & ~sda_oe;

    int          total = 0;
    int          bad = 0;
    int          th = 1250;
    logic [23:0] exp_q[$];
    logic [7:0]  wq[$];
    logic [23:0] exp_e;
    logic        oe_prev = 1'b0;
`ifdef SCCB_SLAVE_RD_EN
    logic [7:0]  mem [256];
`endif

    sccb_slave dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got addr=0x%h data=0x%h, want no write", reg_wr_addr, reg_wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", 32'(reg_wr_addr), 32'(exp_e[23:8]));
                chk("wr_data", 32'(reg_wr_data), 32'(exp_e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (sda_oe && !oe_prev) chk("oe_rise_scl_low", 32'(scl), 32'd0);
        oe_prev = sda_oe;
    end

    task automatic bit_cycle(input logic mb, output logic sb);
        #(th/2) sda_m = mb;
        #(th/2) scl = 1'b1;
        #(th/2) sb = sda_line;
        #(th/2) scl = 1'b0;
    endtask

    task automatic m_start();
        if (scl == 1'b0) begin
            #(th/2) sda_m = 1'b1;
            #(th/2) scl = 1'b1;
        end
        #(th) sda_m = 1'b0;
        #(th) scl = 1'b0;
    endtask

    task automatic m_stop();
        #(th/2) sda_m = 1'b0;
        #(th/2) scl = 1'b1;
        #(th) sda_m = 1'b1;
        #(th);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(~mack, s);
    endtask

    // START, device byte, address, then every byte queued in wq; the caller chooses STOP or repeated START.
    task automatic wr_txn(input string tag, input logic [6:0] dev, input logic [15:0] a);
        logic        ack;
        logic        hit;
        logic [15:0] p;
        logic [7:0]  d;
        hit = (dev == DEV);
        m_start();
        send_byte({dev, 1'b0}, ack);
        chk({tag, "/dev_ack"}, 32'(ack), 32'(hit));
        if (!hit) begin
            wq.delete();
        end else begin
            send_byte(a[15:8], ack);
            chk({tag, "/ahi_ack"}, 32'(ack), 32'd1);
            send_byte(a[7:0], ack);
            chk({tag, "/alo_ack"}, 32'(ack), 32'd1);
            p = a;
            while (wq.size() > 0) begin
                d = wq.pop_front();
                exp_q.push_back({p, d});
`ifdef SCCB_SLAVE_RD_EN
                mem[p[7:0]] = d;
`endif
                send_byte(d, ack);
                chk({tag, "/data_ack"}, 32'(ack), 32'd1);
                p = p + 16'd1;
            end
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] b;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 400 kHz single write
        wq.push_back(8'h82);
        wr_txn("w3008", DEV, 16'h3008);
        chk("busy_in_txn", 32'(busy), 32'd1);
        m_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);

        // Foreign device: NACK, stays idle
        wr_txn("dev42", 7'h21, 16'h0000);
        chk("busy_foreign", 32'(busy), 32'd0);
        m_stop();

        th = 300;
        wq.push_back(8'h11);
        wq.push_back(8'h22);
        wr_txn("wrap", DEV, 16'hFFFF);
        m_stop();

        // STOP after 5 data bits drops the byte; next transfer is normal
        wr_txn("part", DEV, 16'h4300);
        for (int i = 0; i < 5; i++) bit_cycle(1'($urandom), s);
        m_stop();
        wq.push_back(8'($urandom));
        wr_txn("after_part", DEV, 16'h4300);
        m_stop();

`ifdef SCCB_SLAVE_RD_EN
        wq.push_back(8'h3A);
        wq.push_back(8'($urandom));
        wr_txn("rd_prep", DEV, 16'h0005);
        m_stop();
        wr_txn("rd_addr", DEV, 16'h0005);
        m_start();
        send_byte({DEV, 1'b1}, ack);
        chk("rd_dev_ack", 32'(ack), 32'd1);
        recv_byte(1'b1, b);
        chk("rd_byte0", 32'(b), 32'(mem[8'h05]));
        recv_byte(1'b0, b);
        chk("rd_byte1", 32'(b), 32'(mem[8'h06]));
        m_stop();
`else
        m_start();
        send_byte({DEV, 1'b1}, ack);
        chk("rd_nack", 32'(ack), 32'd0);
        m_stop();
`endif

        // Reset in the middle of the address-high byte
        m_start();
        send_byte({DEV, 1'b0}, ack);
        chk("abort_dev_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), s);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sda_oe", 32'(sda_oe), 32'd0);
        chk("abort_wr_en", 32'(reg_wr_en), 32'd0);
        chk("abort_wr_addr", 32'(reg_wr_addr), 32'd0);
        chk("abort_wr_data", 32'(reg_wr_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wq.push_back(8'($urandom));
        wr_txn("post_rst", DEV, 16'($urandom));
        m_stop();

        for (int k = 0; k < 8; k++) begin
            logic [6:0]  dv;
            logic [15:0] a;
            int          n;
            dv = DEV;
            if ($urandom_range(0, 3) == 0) begin
                dv = 7'($urandom);
                if (dv == DEV) dv = dv ^ 7'h01;
            end
            a = 16'($urandom);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
            wr_txn("rnd", dv, a);
            if ($urandom_range(0, 1) == 1) m_stop();
        end
        if (scl == 1'b0) m_stop();

        repeat (20) @(negedge clk);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
